bcd_alu_seq: RTL and testbench
==============================

Name: bcd_alu_seq

Overview:
- Digit-serial BCD add/subtract engine for the RPN calculator. It serves the stack's PLUS and MINUS keys.
- The stack presents two 4-digit packed-BCD operands plus an op code and pulses start. The block sequences one BCD digit per cycle through a single digit adder/subtractor.
- It returns a packed-BCD result with a one-cycle done pulse and an error code. The stack uses the error code to select the error display.

Parameters:
- NDIG, 4, number of BCD digits per operand; operand/result width is 4*NDIG.
- IDXW, 2, digit index counter width; must equal clog2(NDIG).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op_sel  in  1  0 = add (a+b), 1 = subtract (a-b)
- op_a  in  4*NDIG  packed BCD operand a (stack[sp-1]), digit 0 in [3:0]
- op_b  in  4*NDIG  packed BCD operand b (stack[sp])
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, high while state == DONE
- result  out  4*NDIG  packed BCD result; updated only on an error-free completion
- err  out  2  00 none, 01 overflow, 10 negative, 11 invalid digit; valid while done is high, held until next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state = IDLE, busy = 0, done = 0, result = 0, err = 00, internal carry/index/operand registers = 0.
- Reset mid-operation: the operation is abandoned at the next edge and no done is produced.

State machine (IDLE, CHECK, CALC, DONE):
- IDLE: if start = 1, latch op_a, op_b and op_sel, clear err, then go to CHECK. Otherwise stay.
- CHECK (1 cycle):
  - Set the invalid flag if any latched nibble of a or b is > 9.
  - Clear carry/borrow, set idx = 0, clear the accumulator, go to CALC.
- CALC (NDIG cycles): each edge processes digit idx and writes accumulator digit idx.
  - Add: s = a_i + b_i + c (5-bit). If s > 9, digit = s - 10 and c = 1; else digit = s and c = 0.
  - Sub: t = a_i - b_i - c (signed). If t < 0, digit = t + 10 and c = 1; else digit = t and c = 0.
  - At idx = NDIG-1, go to DONE and resolve err with priority invalid(11) > final carry on add(01) > final borrow on sub(10) > 00.
  - result <= accumulator only when the resolved err = 00; otherwise result keeps its previous value.
- DONE (1 cycle): done = 1, then go to IDLE unconditionally.

Latency and handshake:
- Latency is fixed regardless of error: start sampled at edge 0 gives done high in the cycle after edge NDIG+1 (edge 5 for NDIG = 4).
- start while busy, including in the DONE cycle, is ignored. The earliest next acceptance is the edge after DONE.
- Operand inputs may change after the start edge; the latched copies are used.

Arithmetic and boundaries:
- All digit arithmetic stays within 5 bits; no binary-to-BCD conversion.
- Add: 9999 + 0001 gives overflow. 0000 + 0000 gives 0000 with err 00.
- Sub: equal operands give 0000 with err 00. a < b gives negative.

Decomposition:
- Package calc_pkg holds:
  - OP_ADD/OP_SUB constants
  - err codes ERR_NONE/ERR_OVF/ERR_NEG/ERR_BCD
  - the 2-bit state encoding
  - BCD_MAX = 9
  - the key codes shared with the stack (PLUS = 5'b10000, MINUS = 5'b10001)
- One sub-module: bcd_digit_alu. It is combinational, with inputs a[3:0], b[3:0], cin, sub and outputs d[3:0], cout, instantiated once. The FSM, index counter, operand/accumulator registers and err resolution stay in bcd_alu_seq.

Test Plan:
- a=16'h1234, b=16'h4321, add, start at edge 0 -> busy high 6 cycles; done pulse after edge 5; result=16'h5555, err=00.
- a=16'h0999, b=16'h0001, add -> result=16'h1000, err=00 (carry ripples 3 digits). Then a=16'h9999, b=16'h0001 -> err=01, result stays 16'h1000.
- a=16'h0100, b=16'h0001, sub -> result=16'h0099, err=00. Then a=16'h0001, b=16'h0002, sub -> err=10, result stays 16'h0099.
- a=16'h00A5, b=16'h0001, add -> err=11 with the same 5-edge latency; result unchanged. Invalid plus overflow (a=16'h9A99, b=16'h9000) -> err=11.
- Start pulsed again in CHECK, in CALC and in the DONE cycle -> ignored, exactly one done. Start at the edge after DONE -> accepted.
- rst asserted during CALC digit 2 -> next edge busy=0, done=0, result=0, err=00; no done pulse follows. A start afterwards completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the RPN calculator datapath: op codes, error codes,
// sequencer state encoding and the stack key codes.
package calc_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_OVF  = 2'b01,
    ERR_NEG  = 2'b10,
    ERR_BCD  = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_CALC  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [4:0] KEY_PLUS  = 5'b10000;
  localparam logic [4:0] KEY_MINUS = 5'b10001;

endpackage

// File: rtl/bcd_digit_alu.sv
// Single-digit BCD adder/subtractor with carry/borrow in and out.
module bcd_digit_alu
  import calc_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] d,
  output logic       cout
);

  logic [4:0] s;
  logic [4:0] t;

  always_comb begin
    s    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    t    = {1'b0, a} - {1'b0, b} - {4'b0, cin};
    d    = s[3:0];
    cout = 1'b0;
    if (sub) begin
      // t[4] is the sign: a - b - c stays within -16..15
      if (t[4]) begin
        d    = t[3:0] + 4'd10;
        cout = 1'b1;
      end else begin
        d    = t[3:0];
      end
    end else if (s > {1'b0, BCD_MAX}) begin
      // s - 10 modulo 16 equals s + 6
      d    = s[3:0] + 4'd6;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_alu_seq.sv
// Digit-serial packed-BCD add/subtract engine serving the stack's PLUS/MINUS
// keys: one digit per cycle, fixed latency, error code for the display.
module bcd_alu_seq
  import calc_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int IDXW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_sel,
  input  logic [4*NDIG-1:0] op_a,
  input  logic [4*NDIG-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] result,
  output logic [1:0]        err
);

  state_e            state_q, state_d;
  logic [4*NDIG-1:0] a_q, a_d, b_q, b_d;
  logic [4*NDIG-1:0] acc_q, acc_d, result_q, result_d;
  logic              sub_q, sub_d, carry_q, carry_d, inv_q, inv_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  err_e              err_q, err_d;

  logic [3:0] dig_a, dig_b, dig_d;
  logic       dig_cout;
  logic       bad_digit;

  assign dig_a = a_q[{idx_q, 2'b00} +: 4];
  assign dig_b = b_q[{idx_q, 2'b00} +: 4];

  bcd_digit_alu u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .sub  (sub_q),
    .d    (dig_d),
    .cout (dig_cout)
  );

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (a_q[4*i +: 4] > BCD_MAX || b_q[4*i +: 4] > BCD_MAX) bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    acc_d    = acc_q;
    result_d = result_q;
    carry_d  = carry_q;
    inv_d    = inv_q;
    idx_d    = idx_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = op_sel;
          err_d   = ERR_NONE;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        inv_d   = bad_digit;
        carry_d = 1'b0;
        idx_d   = '0;
        acc_d   = '0;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        acc_d[{idx_q, 2'b00} +: 4] = dig_d;
        carry_d = dig_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDXW'(NDIG - 1)) begin
          state_d = ST_DONE;
          if (inv_q)                    err_d = ERR_BCD;
          else if (dig_cout && !sub_q)  err_d = ERR_OVF;
          else if (dig_cout && sub_q)   err_d = ERR_NEG;
          else                          err_d = ERR_NONE;
          // the display keeps showing the last good value on any error
          if (err_d == ERR_NONE) result_d = acc_d;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      inv_q    <= 1'b0;
      idx_q    <= '0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      inv_q    <= inv_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Scoreboard bench for bcd_alu_seq: stimulus pushes expected result/err,
// a negedge monitor pops and compares on every done pulse.
module tb_bcd_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_sel;
  logic [15:0] op_a, op_b;
  logic        busy, done;
  logic [15:0] result;
  logic [1:0]  err;

  typedef struct {
    logic [15:0] res;
    logic [1:0]  err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  bcd_alu_seq #(.NDIG(4), .IDXW(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sel (op_sel),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (result %h err %b)", result, err);
      end else begin
        e = exp_q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("err", 32'(err), 32'(e.err));
      end
    end
  end

  // Issue one op, check busy span and done latency (cycles after start edge).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sel,
                        input logic [15:0] eres, input logic [1:0] eerr);
    int n;
    int nbusy;
    @(negedge clk);
    op_a = a; op_b = b; op_sel = sel; start = 1'b1;
    exp_q.push_back('{res: eres, err: eerr});
    @(negedge clk);
    start = 1'b0;
    op_a = 16'hFFFF; op_b = 16'hFFFF; op_sel = ~sel;
    n = 1;
    nbusy = busy ? 1 : 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
    end
    chk("latency", 32'(n), 32'd6);
    chk("busy_cycles", 32'(nbusy), 32'd6);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int dc0;
    int n;
    rst = 1'b1; start = 1'b0; op_sel = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 2'b00);
    run_op(16'h0999, 16'h0001, 1'b0, 16'h1000, 2'b00);
    run_op(16'h9999, 16'h0001, 1'b0, 16'h1000, 2'b01);
    run_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 2'b00);
    run_op(16'h0100, 16'h0001, 1'b1, 16'h0099, 2'b00);
    run_op(16'h0001, 16'h0002, 1'b1, 16'h0099, 2'b10);
    run_op(16'h00A5, 16'h0001, 1'b0, 16'h0099, 2'b11);
    run_op(16'h9A99, 16'h9000, 1'b0, 16'h0099, 2'b11);
    run_op(16'h4567, 16'h4567, 1'b1, 16'h0000, 2'b00);

    // start pulses during CHECK, CALC and DONE must be ignored
    dc0 = done_cnt;
    @(negedge clk);
    op_a = 16'h0005; op_b = 16'h0003; op_sel = 1'b0; start = 1'b1;
    exp_q.push_back('{res: 16'h0008, err: 2'b00});
    @(negedge clk);                       // CHECK
    op_a = 16'h7777; op_b = 16'h1111; op_sel = 1'b1; start = 1'b1;
    @(negedge clk);                       // CALC digit 0
    start = 1'b0;
    @(negedge clk);                       // CALC digit 1
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ign_done_seen", 32'(done), 32'd1);
    // DONE cycle: this start is sampled on the DONE->IDLE edge and dropped
    op_a = 16'h0020; op_b = 16'h0011; op_sel = 1'b1; start = 1'b1;
    exp_q.push_back('{res: 16'h0009, err: 2'b00});
    @(negedge clk);                       // IDLE: accepted on the next edge
    chk("ign_idle_after_done", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("accept_after_done", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_latency", 32'(n), 32'd5);
    @(negedge clk);
    chk("ign_done_count", 32'(done_cnt - dc0), 32'd2);

    // reset during CALC digit 2 abandons the op
    dc0 = done_cnt;
    @(negedge clk);
    op_a = 16'h1111; op_b = 16'h1111; op_sel = 1'b0; start = 1'b1;
    @(negedge clk);                       // CHECK
    start = 1'b0;
    @(negedge clk);                       // CALC digit 0
    @(negedge clk);                       // CALC digit 1
    @(negedge clk);                       // CALC digit 2
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt - dc0), 32'd0);

    run_op(16'h0042, 16'h0058, 1'b0, 16'h0100, 2'b00);
    run_op(16'h5000, 16'h2500, 1'b1, 16'h2500, 2'b00);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
